// File: rtl/instr_encoder_loader_if.sv
// Decoded-instruction field stream: valid/ready handshake plus the RV32I fields of one instruction.
interface instr_encoder_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        last;

   modport master (
      output in_valid, fmt, op, funct3, funct7b5, rd, rs1, rs2, imm, last,
      input  in_ready
   );

   modport slave (
      input  in_valid, fmt, op, funct3, funct7b5, rd, rs1, rs2, imm, last,
      output in_ready
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I field encoder and instruction-memory loader; writes land one cycle after the accepting edge.
// One beat per cycle while loading; in_ready drops outside LOAD or once the memory is full.
module instr_encoder_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   instr_encoder_loader_if.slave    in_if,
   output logic                     imem_we,
   output logic [AW-1:0]            imem_addr,
   output logic [31:0]              imem_wdata,
   output logic [$clog2(DEPTH):0]   word_count,
   output logic                     cpu_hold,
   output logic                     load_done,
   output logic                     err
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_W  = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [1:0]  state;
   logic [31:0] enc;
   logic        good;
   logic        hs;
   logic        fits12;
   logic        fits13;
   logic        fits21;
   logic [31:0] imm;

   assign imm = in_if.imm;

   // Signed range checks: upper bits must all replicate the field's sign bit.
   assign fits12 = (imm[31:11] == {21{imm[11]}});
   assign fits13 = (imm[31:12] == {20{imm[12]}});
   assign fits21 = (imm[31:20] == {12{imm[20]}});

   assign in_if.in_ready = (state == LOAD) && (word_count < DEPTH_W);
   assign hs             = in_if.in_valid && in_if.in_ready;
   assign cpu_hold       = (state != DONE);
   assign load_done      = (state == DONE);

   always_comb begin
      enc  = '0;
      good = 1'b0;
      case (in_if.fmt)
         FMT_R: begin
            enc  = {1'b0, in_if.funct7b5, 5'b0, in_if.rs2, in_if.rs1, in_if.funct3, in_if.rd, in_if.op};
            good = 1'b1;
         end
         FMT_I: begin
            enc  = {imm[11:0], in_if.rs1, in_if.funct3, in_if.rd, in_if.op};
            good = fits12;
         end
         FMT_S: begin
            enc  = {imm[11:5], in_if.rs2, in_if.rs1, in_if.funct3, imm[4:0], in_if.op};
            good = fits12;
         end
         FMT_B: begin
            enc  = {imm[12], imm[10:5], in_if.rs2, in_if.rs1, in_if.funct3, imm[4:1], imm[11], in_if.op};
            good = fits13 && !imm[0];
         end
         FMT_U: begin
            enc  = {imm[31:12], in_if.rd, in_if.op};
            good = (imm[11:0] == 12'h000);
         end
         FMT_J: begin
            enc  = {imm[20], imm[10:1], imm[11], imm[19:12], in_if.rd, in_if.op};
            good = fits21 && !imm[0];
         end
         default: begin
            enc  = '0;
            good = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         word_count <= '0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= LOAD;
                  word_count <= '0;
                  err        <= 1'b0;
               end
            end
            LOAD: begin
               if (hs) begin
                  if (good) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= AW'(word_count) << 2;
                     imem_wdata <= enc;
                     word_count <= word_count + CW'(1);
                     if (in_if.last) begin
                        state <= DONE;
                     end else if (word_count == LAST_IDX) begin
                        // Memory is full but the image claims more words: flag and stop.
                        err   <= 1'b1;
                        state <= DONE;
                     end
                  end else begin
                     err <= 1'b1;
                     if (in_if.last) begin
                        state <= DONE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader: accepts decoded instruction fields (format, opcode, funct3, funct7b5, register indices, immediate) over a valid/ready stream, packs them into 32-bit RV32I words and writes them into consecutive instruction-memory words. It is the encoding counterpart of the CPU controller/decoder and sits in front of the instruction memory's write port, holding the core in reset until the program image is loaded.

## Interface
- DEPTH, 64: instruction-memory capacity in words (power of two, ≥2).
- AW, 32: width of the byte address on the write port.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new load at word 0.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal.
- op  in  7  opcode field.
- funct3  in  3  funct3 field.
- funct7b5  in  1  bit 30 for R-type; ignored for other formats.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  immediate as a signed (U: full) value.
- last  in  1  marks final instruction of the image.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  AW  byte address = word_index×4.
- imem_wdata  out  32  encoded instruction.
- word_count  out  clog2(DEPTH)+1  words written in current load.
- cpu_hold  out  1  holds the core in reset while high.
- load_done  out  1  image complete.
- err  out  1  sticky: illegal format, immediate out of range, or overflow.

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE: in_ready=0, cpu_hold=1. start → LOAD.
- LOAD: in_ready=1 when word_count<DEPTH. Handshake = in_valid & in_ready; beats without handshake are ignored.
- DONE: cpu_hold=0, load_done=1, in_ready=0. start → LOAD (reload).
- start in LOAD is ignored. Entering LOAD clears word_count, err, load_done; sets cpu_hold=1.
- Encoding (bit 31 first): R = {0,funct7b5,00000, rs2, rs1, funct3, rd, op}; I = {imm[11:0], rs1, funct3, rd, op}; S = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; U = {imm[31:12], rd, op}; J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Range checks: I/S: imm in [-2048, 2047]; B: [-4096, 4094], imm[0]=0; J: [-2^20, 2^20-2], imm[0]=0; U: imm[11:0]=0; R: imm ignored.
- Rejected beat (illegal fmt or range fail): handshake still completes, no write, word_count unchanged, err set. If that beat has last=1, go to DONE anyway.
- Accepted good beat: write at word index word_count, word_count+1. If last=1 → DONE.
- Overflow: good beat written at index DEPTH-1 with last=0 → err set, DONE.

## Timing
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, cpu_hold=1, load_done=0, err=0.
- Write latency 1 cycle: beat accepted at edge N → imem_we=1 with addr/data during cycle N+1, for exactly one cycle; word_count increments at edge N.
- Back-to-back: one beat per cycle sustained; imem_we may stay high on consecutive cycles.
- DONE/load_done/cpu_hold=0 become visible in the same cycle as the final imem_we pulse.
- err asserts the cycle after the offending beat.
- Reset mid-load: all outputs return to reset values on that edge; a pending write is dropped.
- start and reset same cycle: reset wins.

## Test plan
- start, then one R beat (op=0110011, funct3=000, funct7b5=1, rd=3, rs1=1, rs2=2, last=1) → one cycle later imem_we=1, addr=0, wdata=0x402081B3; load_done=1, cpu_hold=0, err=0.
- Stream I (addi x1,x0,5 → 0x00500093), S (sw x2,8(x0) → 0x00202423), B (beq x0,x0,-4 → 0xFE000EE3), J (jal x1,16 → 0x010000EF, last) back-to-back → addrs 0,4,8,12, word_count=4.
- I beat imm=2048 → no write, err=1, word_count unchanged; next valid beat still writes at addr 0.
- B beat imm=3 and fmt=6 beat → both rejected, err=1; U beat imm=0x12345000, rd=5, op=0110111 → wdata=0x123452B7.
- DEPTH=4, five beats no last → four writes, err=1, DONE after fourth, in_ready=0 for fifth.
- Reset asserted cycle after an accept → imem_we=0, word_count=0, IDLE, cpu_hold=1; start from DONE reloads from addr 0 with err cleared.
